cnn_mem_rd_arb: RTL
===================

Name: cnn_mem_rd_arb

Overview:
- Parametrised N-channel read arbiter between CNN read clients (picture, weight, bias, …) and one shared memory read port.
- Generalises the fixed two-port (pic/wgt) read arrangement of the CNN unit to NUM_CH channels.
- Selectable round-robin or fixed-priority arbitration, held ownership for multi-beat transactions, and a grant watchdog.
- Sits between the cnn datapath read clients and the memory-side read interface.

Parameters:
NUM_CH, 2, number of requesting channels (2..8)
ADDR_WIDTH, 19, byte address width
MAX_BYTES_TO_RD, 20, max bytes per request
LOG2_MAX_BYTES_TO_RD, $clog2(MAX_BYTES_TO_RD), size field width
MEM_DATA_BUS, 128, data bus width (bits)
ARB_MODE, 0, 0 = round-robin; 1 = fixed priority (channel 0 highest)
TIMEOUT, 255, cycles in WAIT_GNT before the watchdog fires (0 disables the watchdog)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ch_req  in  NUM_CH  per-channel read request, held until its last grant
ch_start_addr  in  NUM_CH*ADDR_WIDTH  per-channel start address
ch_size_bytes  in  NUM_CH*LOG2_MAX_BYTES_TO_RD  per-channel byte count
ch_gnt  out  NUM_CH  per-channel grant/data-valid, one-hot or zero
ch_data  out  MEM_DATA_BUS  read data, broadcast to all channels
ch_last_valid  out  $clog2(MEM_DATA_BUS/8)  index of the last valid byte, broadcast
ch_last  out  1  last beat of the transaction, broadcast
mem_req  out  1  request to memory
mem_start_addr  out  ADDR_WIDTH  registered address of the owning channel
mem_size_bytes  out  LOG2_MAX_BYTES_TO_RD  registered size of the owning channel
mem_gnt  in  1  memory grant/data-valid
mem_data  in  MEM_DATA_BUS  memory read data
mem_last_valid  in  $clog2(MEM_DATA_BUS/8)  last valid byte index
mem_last  in  1  last beat
owner_id  out  $clog2(NUM_CH) (min 1)  current owner; valid while busy
busy  out  1  transaction in flight
timeout_err  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async, any state): state=IDLE; mem_req=0; mem_start_addr=0; mem_size_bytes=0; ch_gnt=0; owner_id=0; busy=0; timeout_err=0; rr_ptr=0; watchdog counter=0.
- States: IDLE, WAIT_GNT, DATA.
- IDLE:
  - If any ch_req is high, select a winner:
    - ARB_MODE=0: first requester found by searching upward from rr_ptr, with wrap-around.
    - ARB_MODE=1: lowest-index requester.
  - On the next edge: latch the winner's address and size, set owner_id, mem_req=1, busy=1, state=WAIT_GNT.
  - Request-to-mem_req latency is 1 cycle.
- WAIT_GNT:
  - mem_req is held at 1; the counter increments every cycle.
  - mem_gnt=1 with mem_last=1: single-beat transaction complete; go to IDLE next cycle.
  - mem_gnt=1 with mem_last=0: go to DATA.
  - Counter reaches TIMEOUT (TIMEOUT != 0): pulse timeout_err for 1 cycle; drop mem_req; go to IDLE; advance rr_ptr. The channel receives no grant.
- DATA:
  - mem_req drops to 0.
  - Each mem_gnt beat is routed to the owner.
  - mem_gnt && mem_last: go to IDLE.
  - No watchdog in DATA.
- Routing (combinational, 0 latency) while state is WAIT_GNT or DATA:
  - ch_gnt[owner_id]=mem_gnt; all other ch_gnt bits are 0.
  - ch_data, ch_last_valid and ch_last follow the mem_* inputs unchanged.
  - In IDLE, ch_gnt=0 and ch_last=0.
- Completion:
  - The transaction ends on the cycle where mem_gnt && mem_last && busy.
  - busy=0 and state=IDLE from the next cycle.
  - rr_ptr = (owner_id+1) mod NUM_CH; ARB_MODE=1 ignores rr_ptr.
  - A new arbitration happens in IDLE, so back-to-back transactions have a 1-cycle IDLE gap. No request is granted in the completion cycle itself.
- Owner deasserts ch_req mid-transaction: ignored; the transaction completes normally.
- Other channels changing ch_req while busy: no effect until IDLE.
- mem_gnt while in IDLE: ignored; no ch_gnt is produced.
- Address and size are sampled only at arbitration and stay stable on mem_* until the transaction completes.

Decomposition:
- Package cnn_mem_pkg:
  - arb_state_t enum {IDLE, WAIT_GNT, DATA}
  - ARB_RR / ARB_FIXED constants
  - ch_sel_t width helper
- Sub-module cnn_rr_pick: combinational priority picker.
  - Inputs: req vector, rr_ptr, mode.
  - Outputs: winner index, any_req.
  - Reused by the future write-side arbiter.

Test Plan:
1. NUM_CH=2, RR. ch0 req addr=0 size=4; memory grants 2 cycles after mem_req with mem_last=1 → mem_start_addr=0; ch_gnt=2'b01 for 1 cycle; busy drops the next cycle; rr_ptr=1.
2. RR, both channels request continuously; each transaction is a 1-beat grant → owner sequence 0,1,0,1 over 4 transactions; mem_start_addr alternates between ch0 and ch1 (addresses 0 and 128).
3. ARB_MODE=1, NUM_CH=4, ch1 and ch3 requesting continuously → ch1 wins all 4 transactions; ch_gnt[3] is never asserted.
4. Multi-beat: 3 mem_gnt beats, mem_last on the 3rd, mem_data=0xA5.. each beat → ch_gnt[owner] high for exactly 3 cycles; ch_data matches mem_data in the same cycle; mem_req is low during DATA.
5. TIMEOUT=8, no mem_gnt → timeout_err pulses once, 8 cycles after mem_req rises; mem_req drops; the next requester is arbitrated.
6. rst_n asserted during DATA (beat 2 of 3) → all outputs reach their reset values immediately; after release, a pending ch_req is re-arbitrated starting from channel 0.

Source files
------------

// File: rtl/cnn_mem_pkg.sv
// rtl/cnn_mem_pkg.sv - shared types and helpers for the CNN memory-side arbiters
package cnn_mem_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GNT = 2'd1,
      DATA     = 2'd2
   } arb_state_t;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;
   localparam int MAX_CH    = 8;

   typedef logic [$clog2(MAX_CH)-1:0] ch_sel_t;

   // Channel-select width, never narrower than one bit.
   function automatic int ch_sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cnn_rr_pick.sv
// rtl/cnn_rr_pick.sv - combinational round-robin / fixed-priority requester picker
module cnn_rr_pick
   import cnn_mem_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int SEL_W  = ch_sel_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  rr_ptr,
   input  logic              mode,
   output logic [SEL_W-1:0]  winner,
   output logic              any_req
);

   int base;
   int idx;

   // Walk downward so the lowest distance from base is the last one written.
   always_comb begin
      winner  = '0;
      any_req = |req;
      base    = mode ? 0 : int'(rr_ptr);
      idx     = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = base + k;
         if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
         end
         if (req[SEL_W'(idx)]) begin
            winner = SEL_W'(idx);
         end
      end
   end

endmodule

// File: rtl/cnn_mem_rd_arb.sv
// rtl/cnn_mem_rd_arb.sv - N-channel read arbiter onto one shared memory read port
module cnn_mem_rd_arb
   import cnn_mem_pkg::*;
#(
   parameter int NUM_CH               = 2,
   parameter int ADDR_WIDTH           = 19,
   parameter int MAX_BYTES_TO_RD      = 20,
   parameter int LOG2_MAX_BYTES_TO_RD = $clog2(MAX_BYTES_TO_RD),
   parameter int MEM_DATA_BUS         = 128,
   parameter int ARB_MODE             = 0,
   parameter int TIMEOUT              = 255,
   localparam int SEL_W               = ch_sel_w(NUM_CH),
   localparam int LV_W                = $clog2(MEM_DATA_BUS / 8)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_CH-1:0]                      ch_req,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]           ch_start_addr,
   input  logic [NUM_CH*LOG2_MAX_BYTES_TO_RD-1:0] ch_size_bytes,
   output logic [NUM_CH-1:0]                      ch_gnt,
   output logic [MEM_DATA_BUS-1:0]                ch_data,
   output logic [LV_W-1:0]                        ch_last_valid,
   output logic                                   ch_last,
   output logic                                   mem_req,
   output logic [ADDR_WIDTH-1:0]                  mem_start_addr,
   output logic [LOG2_MAX_BYTES_TO_RD-1:0]        mem_size_bytes,
   input  logic                                   mem_gnt,
   input  logic [MEM_DATA_BUS-1:0]                mem_data,
   input  logic [LV_W-1:0]                        mem_last_valid,
   input  logic                                   mem_last,
   output logic [SEL_W-1:0]                       owner_id,
   output logic                                   busy,
   output logic                                   timeout_err
);

   localparam int   CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit   WD_EN     = (TIMEOUT != 0);
   localparam logic PICK_MODE = (ARB_MODE == ARB_FIXED);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   arb_state_t                       state;
   logic [SEL_W-1:0]                 rr_ptr;
   logic [SEL_W-1:0]                 next_ptr;
   logic [SEL_W-1:0]                 winner;
   logic                             any_req;
   logic [CNT_W-1:0]                 wd_cnt;
   logic [ADDR_WIDTH-1:0]            addr_arr [NUM_CH];
   logic [LOG2_MAX_BYTES_TO_RD-1:0]  size_arr [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign addr_arr[g] = ch_start_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign size_arr[g] = ch_size_bytes[g*LOG2_MAX_BYTES_TO_RD +: LOG2_MAX_BYTES_TO_RD];
   end

   cnn_rr_pick #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
   ) u_pick (
      .req     (ch_req),
      .rr_ptr  (rr_ptr),
      .mode    (PICK_MODE),
      .winner  (winner),
      .any_req (any_req)
   );

   assign next_ptr = (owner_id == SEL_W'(NUM_CH - 1)) ? '0 : owner_id + SEL_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         mem_req        <= 1'b0;
         mem_start_addr <= '0;
         mem_size_bytes <= '0;
         owner_id       <= '0;
         busy           <= 1'b0;
         timeout_err    <= 1'b0;
         rr_ptr         <= '0;
         wd_cnt         <= '0;
      end else begin
         timeout_err <= 1'b0;
         unique case (state)
            IDLE: begin
               wd_cnt <= '0;
               if (any_req) begin
                  owner_id       <= winner;
                  mem_start_addr <= addr_arr[winner];
                  mem_size_bytes <= size_arr[winner];
                  mem_req        <= 1'b1;
                  busy           <= 1'b1;
                  state          <= WAIT_GNT;
               end
            end
            WAIT_GNT: begin
               // A grant in the same cycle the watchdog expires still wins.
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  if (mem_last) begin
                     busy   <= 1'b0;
                     rr_ptr <= next_ptr;
                     state  <= IDLE;
                  end else begin
                     state <= DATA;
                  end
               end else if (WD_EN && (wd_cnt == WD_LAST)) begin
                  timeout_err <= 1'b1;
                  mem_req     <= 1'b0;
                  busy        <= 1'b0;
                  rr_ptr      <= next_ptr;
                  state       <= IDLE;
               end else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (mem_gnt && mem_last) begin
                  busy   <= 1'b0;
                  rr_ptr <= next_ptr;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Beats go straight through to the owner with no added latency.
   always_comb begin
      ch_gnt = '0;
      if (busy) begin
         ch_gnt[owner_id] = mem_gnt;
      end
   end

   assign ch_data       = mem_data;
   assign ch_last_valid = mem_last_valid;
   assign ch_last       = busy & mem_last;

endmodule
